// File: rtl/debug_vjtag_pkg.sv
// ---------------------------------------------------------------------------
// debug_vjtag_pkg
//   Shared definitions for the virtual-JTAG debug host master:
//   - default scan geometry (DR / IR widths)
//   - virtual IR codes understood by the CPU debug slave
//   - transaction state enumeration
// ---------------------------------------------------------------------------
package debug_vjtag_pkg;

    localparam int DR_WIDTH_DEF = 38;
    localparam int IR_WIDTH_DEF = 2;

    // Virtual instruction codes of the debug slave.
    localparam logic [1:0] IR_OCIMEM    = 2'b00;
    localparam logic [1:0] IR_TRACEMEM  = 2'b01;
    localparam logic [1:0] IR_BREAK     = 2'b10;
    localparam logic [1:0] IR_TRACECTRL = 2'b11;

    // One transaction walks IDLE -> UIR -> CDR -> SDR -> UDR -> RTI -> IDLE.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UIR  = 3'd1,
        ST_CDR  = 3'd2,
        ST_SDR  = 3'd3,
        ST_UDR  = 3'd4,
        ST_RTI  = 3'd5
    } vjtag_state_e;

endpackage

// File: rtl/debug_vjtag_step_timer.sv
// ---------------------------------------------------------------------------
// debug_vjtag_step_timer
//   Divides clk into virtual-JTAG steps of TCK_DIV cycles each.
//   Ports:
//     clk, reset  - clock, asynchronous active-high reset
//     clear       - restart the step (command accept)
//     run         - a transaction is in progress
//     step_en     - high on the last clk cycle of every step while running
// ---------------------------------------------------------------------------
module debug_vjtag_step_timer #(
    parameter int TCK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic step_en
);

    // A single-cycle step still needs a 1-bit counter to keep widths legal.
    localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TCK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign step_en = run && (cnt_q == CNT_LAST);

endmodule

// File: rtl/debug_vjtag_host_master.sv
// ---------------------------------------------------------------------------
// debug_vjtag_host_master
//   Initiator side of the CPU debug-slave virtual-JTAG interface. One accepted
//   command (IR code + DR word) becomes one IR update followed by one full DR
//   scan; the word captured from tdo is returned on rsp_data.
//   Ports:
//     clk, reset            - clock, asynchronous active-high reset
//     cmd_valid/cmd_ready   - command handshake (ready only when idle)
//     cmd_ir, cmd_data      - instruction and DR word (shifted out LSB first)
//     rsp_valid, rsp_data   - one-cycle completion pulse and captured word
//     busy                  - transaction in progress
//     ir_in                 - instruction presented to the slave
//     vs_uir/vs_cdr/vs_sdr/vs_udr, jtag_state_rti - virtual-state strobes
//     tdi, tdo              - serial data to / from the slave
//     step_en               - last clk cycle of each virtual-JTAG step
//   DR_WIDTH must be at least 2.
// ---------------------------------------------------------------------------
module debug_vjtag_host_master
    import debug_vjtag_pkg::*;
#(
    parameter int DR_WIDTH = DR_WIDTH_DEF,
    parameter int IR_WIDTH = IR_WIDTH_DEF,
    parameter int TCK_DIV  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic                busy,
    output logic [IR_WIDTH-1:0] ir_in,
    output logic                vs_uir,
    output logic                vs_cdr,
    output logic                vs_sdr,
    output logic                vs_udr,
    output logic                jtag_state_rti,
    output logic                tdi,
    input  logic                tdo,
    output logic                step_en
);

    localparam int BW = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(DR_WIDTH - 1);

    vjtag_state_e         state_q, state_d;
    logic [DR_WIDTH-1:0]  sh_q, sh_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [IR_WIDTH-1:0]  ir_q, ir_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [DR_WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic                 accept;
    logic                 running;

    assign running = (state_q != ST_IDLE);

    debug_vjtag_step_timer #(
        .TCK_DIV (TCK_DIV)
    ) u_step_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept),
        .run     (running),
        .step_en (step_en)
    );

    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        bit_cnt_d   = bit_cnt_q;
        ir_d        = ir_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        accept      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_d   = ST_UIR;
                    sh_d      = cmd_data;
                    ir_d      = cmd_ir;
                    bit_cnt_d = '0;
                end
            end
            ST_UIR: if (step_en) state_d = ST_CDR;
            ST_CDR: if (step_en) state_d = ST_SDR;
            ST_SDR: begin
                if (step_en) begin
                    // tdi shows sh[0]; tdo enters at the top so after the last
                    // step the captured bits sit in arrival order, LSB first.
                    sh_d = {tdo, sh_q[DR_WIDTH-1:1]};
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = ST_UDR;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_UDR: if (step_en) state_d = ST_RTI;
            ST_RTI: begin
                if (step_en) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = sh_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the shift register and response word are ordinary registers, so
    // they are reset along with the control state (no RAM involved).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sh_q        <= '0;
            bit_cnt_q   <= '0;
            ir_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            bit_cnt_q   <= bit_cnt_d;
            ir_q        <= ir_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Strobes decode straight from the state register so reset drops them
    // without waiting for a clock.
    assign vs_uir         = (state_q == ST_UIR);
    assign vs_cdr         = (state_q == ST_CDR);
    assign vs_sdr         = (state_q == ST_SDR);
    assign vs_udr         = (state_q == ST_UDR);
    assign jtag_state_rti = (state_q == ST_RTI);

    assign tdi       = vs_sdr ? sh_q[0] : 1'b0;
    assign cmd_ready = !running;
    assign busy      = running;
    assign ir_in     = ir_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule
